// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream boot loader. It parses a command stream and fills
//               the instruction BRAM and data BRAM one 32-bit word at a time.
//               It then releases the single-cycle core from reset and stall.
//
//               Stream grammar:
//                 CMD_INSTR | CMD_DATA, N[7:0], N[15:8], N x (4 bytes, LE)
//                 CMD_RUN   -> core_rst pulse, then the core runs
//                 CMD_HALT  -> (in RUN) stall the core, return to loading
//
//               Ports:
//                 clk, rst            clock, async active-high reset
//                 s_dat/s_valid/s_ready  byte stream handshake
//                 i_w_addr/dat/enb    instruction BRAM write port
//                 d_w_addr/dat/enb    data BRAM write port
//                 pc_stall, core_rst, d_bram_init_done  core control
//                 busy                a section is in progress
//                 error               sticky section-length error
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter int         MAX_WORDS  = 256,
    parameter logic [7:0] CMD_INSTR  = 8'hA5,
    parameter logic [7:0] CMD_DATA   = 8'h5A,
    parameter logic [7:0] CMD_RUN    = 8'hC3,
    parameter logic [7:0] CMD_HALT   = 8'h3C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_dat,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [31:0]           i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [31:0]           d_w_dat,
    output logic                  d_w_enb,
    output logic                  pc_stall,
    output logic                  core_rst,
    output logic                  d_bram_init_done,
    output logic                  busy,
    output logic                  error
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CNT_LO   = 3'd1;
    localparam logic [2:0] CNT_HI   = 3'd2;
    localparam logic [2:0] BYTE     = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] CORE_RST = 3'd5;
    localparam logic [2:0] RUN      = 3'd6;
    localparam logic [2:0] ERROR    = 3'd7;

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic        r_sect_data;   // 1: current section targets data BRAM
    logic [15:0] r_count;       // word count N of the current section
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;       // first three payload bytes of a word

    logic        w_xfer;
    logic [15:0] w_n;
    logic [31:0] w_word;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign s_ready = (r_state != WRITE) && (r_state != CORE_RST);
    assign w_xfer  = s_valid && s_ready;
    // Count is complete when the high byte arrives; combine it with the low
    // byte already held in r_count.
    assign w_n     = {s_dat, r_count[7:0]};
    // The 4th byte lands directly in bits [31:24] so the write can be
    // registered on the same edge that accepts it.
    assign w_word  = {s_dat, r_shift};
    assign w_addr  = {r_word_idx[ADDR_WIDTH-3:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_sect_data      <= 1'b0;
            r_count          <= 16'd0;
            r_word_idx       <= 16'd0;
            r_byte_cnt       <= 2'd0;
            r_shift          <= 24'd0;
            i_w_addr         <= '0;
            i_w_dat          <= 32'd0;
            i_w_enb          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= 32'd0;
            d_w_enb          <= 1'b0;
            pc_stall         <= 1'b1;
            core_rst         <= 1'b0;
            d_bram_init_done <= 1'b0;
            busy             <= 1'b0;
            error            <= 1'b0;
        end else begin
            // Pulses last exactly the one cycle after they are set.
            i_w_enb  <= 1'b0;
            d_w_enb  <= 1'b0;
            core_rst <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (s_dat == CMD_INSTR || s_dat == CMD_DATA) begin
                            r_sect_data <= (s_dat == CMD_DATA);
                            r_word_idx  <= 16'd0;
                            r_state     <= CNT_LO;
                        end else if (s_dat == CMD_RUN) begin
                            core_rst <= 1'b1;
                            r_state  <= CORE_RST;
                        end
                    end
                end

                CNT_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= s_dat;
                        r_state      <= CNT_HI;
                    end
                end

                CNT_HI: begin
                    if (w_xfer) begin
                        r_count <= w_n;
                        if (w_n == 16'd0) begin
                            r_state <= IDLE;
                        end else if ({1'b0, w_n} > c_max_words) begin
                            error   <= 1'b1;
                            r_state <= ERROR;
                        end else begin
                            busy       <= 1'b1;
                            r_byte_cnt <= 2'd0;
                            r_state    <= BYTE;
                        end
                    end
                end

                BYTE: begin
                    if (w_xfer) begin
                        if (r_byte_cnt == 2'd3) begin
                            if (r_sect_data) begin
                                d_w_enb  <= 1'b1;
                                d_w_addr <= w_addr;
                                d_w_dat  <= w_word;
                            end else begin
                                i_w_enb  <= 1'b1;
                                i_w_addr <= w_addr;
                                i_w_dat  <= w_word;
                            end
                            r_byte_cnt <= 2'd0;
                            r_state    <= WRITE;
                        end else begin
                            r_shift    <= {s_dat, r_shift[23:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                    if (r_word_idx == r_count - 16'd1) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= BYTE;
                    end
                end

                CORE_RST: begin
                    pc_stall         <= 1'b0;
                    d_bram_init_done <= 1'b1;
                    r_state          <= RUN;
                end

                RUN: begin
                    if (w_xfer && s_dat == CMD_HALT) begin
                        pc_stall         <= 1'b1;
                        d_bram_init_done <= 1'b0;
                        r_state          <= IDLE;
                    end
                end

                ERROR: begin
                    r_state <= ERROR;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Expected BRAM writes are
//               queued when their payload is sent and compared when the
//               loader pulses a write enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_dat = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] i_w_addr;
    logic [31:0]   i_w_dat;
    logic          i_w_enb;
    logic [AW-1:0] d_w_addr;
    logic [31:0]   d_w_dat;
    logic          d_w_enb;
    logic          pc_stall;
    logic          core_rst;
    logic          d_bram_init_done;
    logic          busy;
    logic          error;

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_dat            (s_dat),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .pc_stall         (pc_stall),
        .core_rst         (core_rst),
        .d_bram_init_done (d_bram_init_done),
        .busy             (busy),
        .error            (error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit throttle = 1'b0;
    logic [AW-1:0] last_d_addr = '0;

    typedef struct packed {
        logic          port;   // 1: data BRAM
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } wr_t;

    wr_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every enable pulse must match the oldest queued write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (i_w_enb || d_w_enb) begin
                chk("single_enb", {63'd0, i_w_enb & d_w_enb}, 64'd0);
                chk("sready_in_write", {63'd0, s_ready}, 64'd0);
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_write: observed write addr i=%0h d=%0h, expected no write", i_w_addr, d_w_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_port", {63'd0, d_w_enb}, {63'd0, e.port});
                    chk("wr_addr", 64'(d_w_enb ? d_w_addr : i_w_addr), 64'(e.addr));
                    chk("wr_dat", 64'(d_w_enb ? d_w_dat : i_w_dat), 64'(e.dat));
                end
                if (d_w_enb) last_d_addr = d_w_addr;
            end
            if (!s_ready)
                chk("sready_low_only_write_or_corerst", {63'd0, i_w_enb | d_w_enb | core_rst}, 64'd1);
        end
    end

    // Called and returns one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        s_dat   = b;
        s_valid = 1'b1;
        while (!s_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        assert (guard < 20) else begin
            n_fail++;
            $error("FAIL send_timeout: observed s_ready low for %0d cycles, expected high within 20", guard);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (throttle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic port, input logic [AW-1:0] addr, input logic [31:0] w);
        sb.push_back({port, addr, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        // With throttling an idle cycle was already inserted after the 4th byte.
        if (!throttle)
            chk("wr_pulse_after_4th_byte", {63'd0, port ? d_w_enb : i_w_enb}, 64'd1);
    endtask

    function automatic logic [31:0] word_of(input int seed, input int i);
        return {8'(i), 8'(seed), 8'(i * 7 + 3), 8'(i >> 8) ^ 8'hC0};
    endfunction

    task automatic load_section(input logic port, input int n, input int seed);
        logic [15:0] cnt;
        cnt = 16'(n);
        send_byte(port ? 8'h5A : 8'hA5);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        for (int i = 0; i < n; i++) send_word(port, AW'(i * 4), word_of(seed, i));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"},  {63'd0, s_ready}, 64'd1);
        chk({tag, "_pc_stall"}, {63'd0, pc_stall}, 64'd1);
        chk({tag, "_core_rst"}, {63'd0, core_rst}, 64'd0);
        chk({tag, "_init_done"}, {63'd0, d_bram_init_done}, 64'd0);
        chk({tag, "_busy"},     {63'd0, busy}, 64'd0);
        chk({tag, "_error"},    {63'd0, error}, 64'd0);
        chk({tag, "_enb"},      {62'd0, i_w_enb, d_w_enb}, 64'd0);
        chk({tag, "_addr"},     64'({i_w_addr, d_w_addr}), 64'd0);
        chk({tag, "_dat"},      {i_w_dat, d_w_dat}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    initial begin
        // Reset state
        cycles(3);
        check_reset_vals("reset");
        rst = 1'b0;
        cycles(1);

        // Instruction section: A5 02 00 | 13 05 10 00 | 93 05 20 00
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        chk("busy_in_section", {63'd0, busy}, 64'd1);
        send_word(1'b0, 10'h000, 32'h00100513);
        send_word(1'b0, 10'h004, 32'h00200593);
        chk("busy_at_last_write", {63'd0, busy}, 64'd1);
        cycles(1);
        chk("busy_falls", {63'd0, busy}, 64'd0);
        chk("sb_empty_instr", 64'(sb.size()), 64'd0);

        // Data section, then RUN
        send_byte(8'h5A); send_byte(8'h02); send_byte(8'h00);
        send_word(1'b1, 10'h000, 32'h00100513);
        send_word(1'b1, 10'h004, 32'h00200593);
        cycles(1);
        chk("sb_empty_data", 64'(sb.size()), 64'd0);
        send_byte(8'hC3);
        chk("core_rst_pulse", {61'd0, core_rst, pc_stall, d_bram_init_done}, 64'b110);
        cycles(1);
        chk("run_entry", {61'd0, core_rst, pc_stall, d_bram_init_done}, 64'b001);
        // Commands other than HALT are discarded in RUN; monitor flags any write.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5A);
        chk("run_ignores_bytes", {62'd0, pc_stall, d_bram_init_done}, 64'b01);

        // HALT, then a fresh instruction section
        send_byte(8'h3C);
        chk("halt", {62'd0, pc_stall, d_bram_init_done}, 64'b10);
        load_section(1'b0, 3, 7);
        cycles(1);
        chk("sb_empty_after_halt", 64'(sb.size()), 64'd0);

        // Zero-length section writes nothing
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00);
        cycles(2);
        chk("zero_len_idle", {62'd0, busy, error}, 64'd0);

        // Oversized section: 257 words
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        chk("oversize_error", {62'd0, error, busy}, 64'b10);
        send_byte(8'hC3);
        cycles(3);
        chk("error_blocks_run", {60'd0, pc_stall, core_rst, error, s_ready}, 64'b1011);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        cycles(2);
        chk("error_sticky", {62'd0, error, pc_stall}, 64'b11);
        do_reset();
        check_reset_vals("after_error_reset");

        // Throttled full-size data section
        throttle = 1'b1;
        load_section(1'b1, 256, 3);
        throttle = 1'b0;
        cycles(2);
        chk("sb_empty_full", 64'(sb.size()), 64'd0);
        chk("last_addr_3fc", 64'(last_d_addr), 64'h3FC);
        chk("busy_after_full", {63'd0, busy}, 64'd0);

        // Asynchronous reset after two payload bytes, then resend
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEE); send_byte(8'hFF);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(1'b0, 10'h000, 32'h44332211);
        cycles(1);
        chk("sb_empty_resend", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
